// File: rtl/ap_sel_bank.sv
// ap_sel_bank: bank of NCH select registers driven through a valid/ready
// command port (LOAD / INC / DEC / CLEAR_ALL / COMMIT).
// Optional feature macro: AP_SHADOW_EN adds a shadow register per channel.
// When it is defined, LOAD/INC/DEC write the shadows and COMMIT copies them
// to the live selects. Without it, COMMIT is an illegal command.
module ap_sel_bank #(
  parameter int NCH     = 4,
  parameter int SEL_W   = 4,
  parameter int SEL_MAX = 2**SEL_W-1,
  parameter int WRAP    = 1,
  localparam int CH_W   = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [CH_W-1:0]      cmd_ch,
  input  logic [SEL_W:0]       cmd_arg,
  output logic [NCH*SEL_W-1:0] sel_flat,
  output logic [NCH-1:0]       sel_upd,
  output logic                 cmd_err
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_INC    = 3'd2;
  localparam logic [2:0] OP_DEC    = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;
  localparam logic [2:0] OP_COMMIT = 3'd5;

  // Highest legal select value, held one bit wider for the arithmetic.
  localparam logic [SEL_W:0] MAXV = (SEL_W+1)'(SEL_MAX);

  typedef enum logic {IDLE, CLR} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]  sel_q [NCH];
  logic [SEL_W-1:0]  sel_d [NCH];
  logic [NCH-1:0]    upd_d;
  logic              err_d;
`ifdef AP_SHADOW_EN
  logic [SEL_W-1:0]  shd_q [NCH];
  logic [SEL_W-1:0]  shd_d [NCH];
`endif

  logic              ch_ok;
  logic              wr;
  logic [SEL_W:0]    base;
  logic [SEL_W:0]    ext;
  logic [SEL_W-1:0]  tgt;

  assign cmd_ready = (state_q == IDLE);

  // Flatten the live selects onto the output bus, channel k at k*SEL_W.
  always_comb begin
    sel_flat = '0;
    for (int k = 0; k < NCH; k++) begin
      sel_flat[k*SEL_W +: SEL_W] = sel_q[k];
    end
  end

  // Decode the command, compute the new select values and the FSM next state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
`ifdef AP_SHADOW_EN
    shd_d   = shd_q;
`endif
    upd_d   = '0;
    err_d   = 1'b0;
    wr      = 1'b0;
    ext     = '0;
    base    = '0;
    ch_ok   = (int'(cmd_ch) < NCH);

    // Base value for INC/DEC: the shadow when present, otherwise the live value.
    for (int k = 0; k < NCH; k++) begin
      if (CH_W'(k) == cmd_ch) begin
`ifdef AP_SHADOW_EN
        base = {1'b0, shd_q[k]};
`else
        base = {1'b0, sel_q[k]};
`endif
      end
    end

    // Target value computed at SEL_W+1 bits, then clamped or wrapped.
    case (cmd_op)
      OP_LOAD: begin
        wr  = (cmd_arg != '0);
        ext = cmd_arg - (SEL_W+1)'(1);
        if (ext > MAXV) ext = MAXV;
      end
      OP_INC: begin
        wr = 1'b1;
        if (base >= MAXV) ext = (WRAP != 0) ? '0 : MAXV;
        else              ext = base + (SEL_W+1)'(1);
      end
      OP_DEC: begin
        wr = 1'b1;
        if (base == '0) ext = (WRAP != 0) ? MAXV : '0;
        else            ext = base - (SEL_W+1)'(1);
      end
      default: begin
        wr  = 1'b0;
        ext = '0;
      end
    endcase
    tgt = ext[SEL_W-1:0];

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP: begin
            end
            OP_LOAD, OP_INC, OP_DEC: begin
              if (!ch_ok) begin
                err_d = 1'b1;
              end else if (wr) begin
                for (int k = 0; k < NCH; k++) begin
                  if (CH_W'(k) == cmd_ch) begin
`ifdef AP_SHADOW_EN
                    shd_d[k] = tgt;
`else
                    sel_d[k] = tgt;
                    upd_d[k] = (sel_q[k] != tgt);
`endif
                  end
                end
              end
            end
            OP_CLEAR: begin
              state_d = CLR;
              idx_d   = '0;
            end
            OP_COMMIT: begin
`ifdef AP_SHADOW_EN
              for (int k = 0; k < NCH; k++) begin
                sel_d[k] = shd_q[k];
                upd_d[k] = (sel_q[k] != shd_q[k]);
              end
`else
              err_d = 1'b1;
`endif
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end
      CLR: begin
        for (int k = 0; k < NCH; k++) begin
          if (CH_W'(k) == idx_q) begin
            sel_d[k] = '0;
            upd_d[k] = (sel_q[k] != '0);
`ifdef AP_SHADOW_EN
            shd_d[k] = '0;
`endif
          end
        end
        if (idx_q == CH_W'(NCH-1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CH_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Register FSM state, clear index, selects and the one-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_upd <= '0;
      cmd_err <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        sel_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_upd <= upd_d;
      cmd_err <= err_d;
      for (int k = 0; k < NCH; k++) begin
        sel_q[k] <= sel_d[k];
      end
    end
  end

`ifdef AP_SHADOW_EN
  // Register the shadow selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        shd_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        shd_q[k] <= shd_d[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_ap_sel_bank.sv
// Directed testbench for ap_sel_bank.
// dut_a: defaults (NCH=4, WRAP=1). dut_b: NCH=5, WRAP=0 (saturation and
// out-of-range channel). Expectations adapt to AP_SHADOW_EN when defined.
module tb_ap_sel_bank;

  logic        clk;
  logic        rst_n;

  logic        a_valid, a_ready, a_err;
  logic [2:0]  a_op;
  logic [1:0]  a_ch;
  logic [4:0]  a_arg;
  logic [15:0] a_flat;
  logic [3:0]  a_upd;

  logic        b_valid, b_ready, b_err;
  logic [2:0]  b_op;
  logic [2:0]  b_ch;
  logic [4:0]  b_arg;
  logic [19:0] b_flat;
  logic [4:0]  b_upd;

  int n_chk;
  int n_fail;

  ap_sel_bank dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_op(a_op), .cmd_ch(a_ch), .cmd_arg(a_arg), .sel_flat(a_flat),
    .sel_upd(a_upd), .cmd_err(a_err)
  );

  ap_sel_bank #(.NCH(5), .WRAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(b_op), .cmd_ch(b_ch), .cmd_arg(b_arg), .sel_flat(b_flat),
    .sel_upd(b_upd), .cmd_err(b_err)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one command to dut_a for one edge; returns 1 unit after that edge.
  task automatic send_a(input logic [2:0] op, input logic [1:0] ch, input logic [4:0] arg);
    a_valid = 1'b1; a_op = op; a_ch = ch; a_arg = arg;
    @(posedge clk); #1;
    a_valid = 1'b0; a_op = 3'd0; a_ch = 2'd0; a_arg = 5'd0;
  endtask

  task automatic send_b(input logic [2:0] op, input logic [2:0] ch, input logic [4:0] arg);
    b_valid = 1'b1; b_op = op; b_ch = ch; b_arg = arg;
    @(posedge clk); #1;
    b_valid = 1'b0; b_op = 3'd0; b_ch = 3'd0; b_arg = 5'd0;
  endtask

  // Update a live select: with shadows, the command is followed by a COMMIT.
  task automatic set_a(input logic [2:0] op, input logic [1:0] ch, input logic [4:0] arg);
    send_a(op, ch, arg);
`ifdef AP_SHADOW_EN
    send_a(3'd5, 2'd0, 5'd0);
`endif
  endtask

  task automatic set_b(input logic [2:0] op, input logic [2:0] ch, input logic [4:0] arg);
    send_b(op, ch, arg);
`ifdef AP_SHADOW_EN
    send_b(3'd5, 3'd0, 5'd0);
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_valid = 1'b0; a_op = '0; a_ch = '0; a_arg = '0;
    b_valid = 1'b0; b_op = '0; b_ch = '0; b_arg = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (a_flat !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_flat got %h want %h", a_flat, 16'h0000); end
    n_chk++; if (a_upd !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_upd got %b want %b", a_upd, 4'b0000); end
    n_chk++; if (a_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got %b want 0", a_err); end
    n_chk++; if (a_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 1", a_ready); end
    n_chk++; if (b_flat !== 20'h00000) begin n_fail++; $display("[TB] FAIL reset_b_flat got %h want %h", b_flat, 20'h00000); end
  endtask

  task automatic test_load;
    set_a(3'd1, 2'd2, 5'd5);
    n_chk++; if (a_flat !== 16'h0400) begin n_fail++; $display("[TB] FAIL load_flat got %h want %h", a_flat, 16'h0400); end
    n_chk++; if (a_upd !== 4'b0100) begin n_fail++; $display("[TB] FAIL load_upd got %b want %b", a_upd, 4'b0100); end
    @(posedge clk); #1;
    n_chk++; if (a_upd !== 4'b0000) begin n_fail++; $display("[TB] FAIL load_upd_one_cycle got %b want %b", a_upd, 4'b0000); end
    set_a(3'd1, 2'd2, 5'd0);
    n_chk++; if (a_flat !== 16'h0400) begin n_fail++; $display("[TB] FAIL load0_flat got %h want %h", a_flat, 16'h0400); end
    n_chk++; if (a_upd !== 4'b0000) begin n_fail++; $display("[TB] FAIL load0_upd got %b want %b", a_upd, 4'b0000); end
  endtask

  task automatic test_wrap;
    set_a(3'd1, 2'd1, 5'd16);
    n_chk++; if (a_flat !== 16'h04F0) begin n_fail++; $display("[TB] FAIL wrap_load_clamp got %h want %h", a_flat, 16'h04F0); end
    set_a(3'd2, 2'd1, 5'd0);
    n_chk++; if (a_flat !== 16'h0400) begin n_fail++; $display("[TB] FAIL wrap_inc_flat got %h want %h", a_flat, 16'h0400); end
    n_chk++; if (a_upd !== 4'b0010) begin n_fail++; $display("[TB] FAIL wrap_inc_upd got %b want %b", a_upd, 4'b0010); end
    set_a(3'd3, 2'd0, 5'd0);
    n_chk++; if (a_flat !== 16'h040F) begin n_fail++; $display("[TB] FAIL wrap_dec_flat got %h want %h", a_flat, 16'h040F); end
    n_chk++; if (a_upd !== 4'b0001) begin n_fail++; $display("[TB] FAIL wrap_dec_upd got %b want %b", a_upd, 4'b0001); end
    set_a(3'd1, 2'd0, 5'd1);
    n_chk++; if (a_flat !== 16'h0400) begin n_fail++; $display("[TB] FAIL wrap_restore got %h want %h", a_flat, 16'h0400); end
  endtask

  task automatic test_saturate;
    set_b(3'd1, 3'd1, 5'd16);
    n_chk++; if (b_flat !== 20'h000F0) begin n_fail++; $display("[TB] FAIL sat_load got %h want %h", b_flat, 20'h000F0); end
    n_chk++; if (b_upd !== 5'b00010) begin n_fail++; $display("[TB] FAIL sat_load_upd got %b want %b", b_upd, 5'b00010); end
    set_b(3'd2, 3'd1, 5'd0);
    n_chk++; if (b_flat !== 20'h000F0) begin n_fail++; $display("[TB] FAIL sat_inc_flat got %h want %h", b_flat, 20'h000F0); end
    n_chk++; if (b_upd !== 5'b00000) begin n_fail++; $display("[TB] FAIL sat_inc_upd got %b want %b", b_upd, 5'b00000); end
    set_b(3'd3, 3'd0, 5'd0);
    n_chk++; if (b_flat !== 20'h000F0) begin n_fail++; $display("[TB] FAIL sat_dec_flat got %h want %h", b_flat, 20'h000F0); end
    n_chk++; if (b_upd !== 5'b00000) begin n_fail++; $display("[TB] FAIL sat_dec_upd got %b want %b", b_upd, 5'b00000); end
  endtask

  task automatic test_clear;
    logic [15:0] exp_flat [4];
    logic [3:0]  exp_upd  [4];
    logic        exp_rdy  [4];
    exp_flat = '{16'h9070, 16'h9000, 16'h9000, 16'h0000};
    exp_upd  = '{4'b0001, 4'b0010, 4'b0000, 4'b1000};
    exp_rdy  = '{1'b0, 1'b0, 1'b0, 1'b1};
    set_a(3'd1, 2'd0, 5'd4);
    set_a(3'd1, 2'd1, 5'd8);
    set_a(3'd1, 2'd2, 5'd1);
    set_a(3'd1, 2'd3, 5'd10);
    n_chk++; if (a_flat !== 16'h9073) begin n_fail++; $display("[TB] FAIL clr_setup got %h want %h", a_flat, 16'h9073); end
    send_a(3'd4, 2'd0, 5'd0);
    n_chk++; if (a_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_ready_c0 got %b want 0", a_ready); end
    n_chk++; if (a_flat !== 16'h9073) begin n_fail++; $display("[TB] FAIL clr_flat_c0 got %h want %h", a_flat, 16'h9073); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_chk++; if (a_flat !== exp_flat[i]) begin n_fail++; $display("[TB] FAIL clr_flat_%0d got %h want %h", i, a_flat, exp_flat[i]); end
      n_chk++; if (a_upd !== exp_upd[i]) begin n_fail++; $display("[TB] FAIL clr_upd_%0d got %b want %b", i, a_upd, exp_upd[i]); end
      n_chk++; if (a_ready !== exp_rdy[i]) begin n_fail++; $display("[TB] FAIL clr_ready_%0d got %b want %b", i, a_ready, exp_rdy[i]); end
    end
  endtask

  task automatic test_back_to_back;
    set_a(3'd1, 2'd1, 5'd2);
    n_chk++; if (a_flat !== 16'h0010) begin n_fail++; $display("[TB] FAIL b2b_first got %h want %h", a_flat, 16'h0010); end
    n_chk++; if (a_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready got %b want 1", a_ready); end
    set_a(3'd2, 2'd1, 5'd0);
    n_chk++; if (a_flat !== 16'h0020) begin n_fail++; $display("[TB] FAIL b2b_second got %h want %h", a_flat, 16'h0020); end
    n_chk++; if (a_upd !== 4'b0010) begin n_fail++; $display("[TB] FAIL b2b_upd got %b want %b", a_upd, 4'b0010); end
  endtask

  task automatic test_illegal;
    send_a(3'd6, 2'd0, 5'd3);
    n_chk++; if (a_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_op6_err got %b want 1", a_err); end
    n_chk++; if (a_flat !== 16'h0020) begin n_fail++; $display("[TB] FAIL ill_op6_flat got %h want %h", a_flat, 16'h0020); end
    send_a(3'd7, 2'd1, 5'd3);
    n_chk++; if (a_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_op7_err got %b want 1", a_err); end
    @(posedge clk); #1;
    n_chk++; if (a_err !== 1'b0) begin n_fail++; $display("[TB] FAIL ill_err_one_cycle got %b want 0", a_err); end
    send_b(3'd1, 3'd5, 5'd3);
    n_chk++; if (b_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_ch5_err got %b want 1", b_err); end
    n_chk++; if (b_flat !== 20'h000F0) begin n_fail++; $display("[TB] FAIL ill_ch5_flat got %h want %h", b_flat, 20'h000F0); end
    n_chk++; if (b_upd !== 5'b00000) begin n_fail++; $display("[TB] FAIL ill_ch5_upd got %b want %b", b_upd, 5'b00000); end
  endtask

  task automatic test_commit;
`ifdef AP_SHADOW_EN
    send_a(3'd1, 2'd0, 5'd3);
    n_chk++; if (a_flat !== 16'h0020) begin n_fail++; $display("[TB] FAIL shd_load_flat got %h want %h", a_flat, 16'h0020); end
    send_a(3'd2, 2'd0, 5'd0);
    n_chk++; if (a_flat !== 16'h0020) begin n_fail++; $display("[TB] FAIL shd_inc_flat got %h want %h", a_flat, 16'h0020); end
    n_chk++; if (a_upd !== 4'b0000) begin n_fail++; $display("[TB] FAIL shd_inc_upd got %b want %b", a_upd, 4'b0000); end
    send_a(3'd5, 2'd0, 5'd0);
    n_chk++; if (a_flat !== 16'h0023) begin n_fail++; $display("[TB] FAIL shd_commit_flat got %h want %h", a_flat, 16'h0023); end
    n_chk++; if (a_upd !== 4'b0001) begin n_fail++; $display("[TB] FAIL shd_commit_upd got %b want %b", a_upd, 4'b0001); end
`else
    send_a(3'd5, 2'd0, 5'd0);
    n_chk++; if (a_err !== 1'b1) begin n_fail++; $display("[TB] FAIL commit_err got %b want 1", a_err); end
    n_chk++; if (a_flat !== 16'h0020) begin n_fail++; $display("[TB] FAIL commit_flat got %h want %h", a_flat, 16'h0020); end
    n_chk++; if (a_upd !== 4'b0000) begin n_fail++; $display("[TB] FAIL commit_upd got %b want %b", a_upd, 4'b0000); end
`endif
  endtask

  task automatic test_reset_mid_clr;
    set_a(3'd1, 2'd3, 5'd10);
    n_chk++; if (a_flat[15:12] !== 4'h9) begin n_fail++; $display("[TB] FAIL mid_setup got %h want 9", a_flat[15:12]); end
    send_a(3'd4, 2'd0, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++; if (a_flat !== 16'h0000) begin n_fail++; $display("[TB] FAIL mid_rst_flat got %h want %h", a_flat, 16'h0000); end
    n_chk++; if (a_upd !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_rst_upd got %b want %b", a_upd, 4'b0000); end
    n_chk++; if (b_flat !== 20'h00000) begin n_fail++; $display("[TB] FAIL mid_rst_b_flat got %h want %h", b_flat, 20'h00000); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (a_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rel_ready got %b want 1", a_ready); end
    n_chk++; if (a_flat !== 16'h0000) begin n_fail++; $display("[TB] FAIL mid_rel_flat got %h want %h", a_flat, 16'h0000); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset;
    test_load;
    test_wrap;
    test_saturate;
    test_clear;
    test_back_to_back;
    test_illegal;
    test_commit;
    test_reset_mid_clr;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
